sample_delta_8: RTL and testbench

Streaming first-difference stage that sits directly upstream of the 8-bit absolute-value block. It accepts unsigned 8-bit samples over a valid/ready handshake, remembers the last accepted sample, and emits the 9-bit two's-complement difference (new − previous) for each sample after the first. The output is registered and backpressure-aware so the absolute-value stage, or any magnitude or threshold logic behind it, can stall it safely.

---
 rtl/sample_delta_8_pkg.sv | 9 +
 rtl/sample_delta_8_stream_reg.sv | 32 +++
 rtl/sample_delta_8.sv | 64 ++++++
 tb/tb_sample_delta_8.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_delta_8_pkg.sv
// Shared definitions for the sample_delta_8 first-difference stage.
package sample_delta_8_pkg;

    typedef enum logic {
        ST_EMPTY  = 1'b0,
        ST_PRIMED = 1'b1
    } delta_state_t;

endpackage

// File: rtl/sample_delta_8_stream_reg.sv
// One-entry valid/ready output register: load, hold while stalled, drain on handshake.
module stream_reg #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    output logic         can_load,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    // The slot is free when empty or when its current contents leave this cycle.
    assign can_load = !out_valid || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sample_delta_8.sv
// Streaming first-difference: emits (new - previous) for every accepted sample after the first.
module sample_delta_8
    import sample_delta_8_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] in_sample,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [DATA_W:0]   out_delta,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  delta_count
);

    delta_state_t      state;
    logic [DATA_W-1:0] prev;
    logic              accept;
    logic              load_delta;
    logic [DATA_W:0]   delta;

    assign accept = in_valid && in_ready;
    // A flush in the same cycle discards the old prev, so no delta is formed.
    assign load_delta = accept && (state == ST_PRIMED) && !flush;
    assign delta = {1'b0, in_sample} - {1'b0, prev};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_EMPTY;
            prev  <= '0;
        end else if (accept) begin
            state <= ST_PRIMED;
            prev  <= in_sample;
        end else if (flush) begin
            state <= ST_EMPTY;
        end
    end

    stream_reg #(
        .W(DATA_W + 1)
    ) u_out_reg (
        .clock     (clock),
        .reset_n   (reset_n),
        .load      (load_delta),
        .load_data (delta),
        .can_load  (in_ready),
        .out_data  (out_delta),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            delta_count <= '0;
        end else if (out_valid && out_ready && (delta_count != {CNT_W{1'b1}})) begin
            delta_count <= delta_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_delta_8.sv
// Scoreboard bench for sample_delta_8: expected deltas queued at accept, checked at handshake.
module tb_sample_delta_8;

    logic        clock;
    logic        reset_n;
    logic [7:0]  in_sample;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [8:0]  out_delta;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] delta_count;

    logic        sat_in_ready;
    logic [8:0]  sat_out_delta;
    logic        sat_out_valid;
    logic [1:0]  sat_count;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_q[$];
    bit         have_prev;
    logic [7:0] model_prev;

    sample_delta_8 dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .flush       (flush),
        .out_delta   (out_delta),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .delta_count (delta_count)
    );

    sample_delta_8 #(.CNT_W(2)) dut_sat (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_sample   (in_sample),
        .in_valid    (in_valid),
        .in_ready    (sat_in_ready),
        .flush       (flush),
        .out_delta   (sat_out_delta),
        .out_valid   (sat_out_valid),
        .out_ready   (out_ready),
        .delta_count (sat_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Handshake monitor: out_valid/out_ready at the negedge decide the next posedge transfer.
    always @(negedge clock) begin
        logic [8:0] exp;
        if (reset_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_delta: got %h, none expected", out_delta);
            end else begin
                exp = exp_q.pop_front();
                if (out_delta !== exp) begin
                    errors++;
                    $display("FAIL delta_value: got %h, expected %h", out_delta, exp);
                end
                checks++;
                if (sat_out_delta !== exp) begin
                    errors++;
                    $display("FAIL sat_delta_value: got %h, expected %h", sat_out_delta, exp);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(posedge clock); #1;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        in_sample = '0;
        #12;
        reset_n = 1'b1;
        exp_q.delete();
        have_prev  = 1'b0;
        model_prev = '0;
        @(posedge clock); #1;
    endtask

    // Drive one sample (optionally with flush) until accepted, then update the model.
    task automatic send(input logic [7:0] s, input bit fl);
        bit got = 1'b0;
        in_sample = s;
        in_valid  = 1'b1;
        flush     = fl;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: sample %0d not accepted, got in_ready=%b expected 1", s, in_ready);
        end
        @(posedge clock); #1;
        if (got) begin
            if (have_prev && !fl)
                exp_q.push_back({1'b0, s} - {1'b0, model_prev});
            have_prev  = 1'b1;
            model_prev = s;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: got %0d pending, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        apply_reset();
        checks += 5;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        if (out_delta !== 9'h000) begin errors++; $display("FAIL reset_out_delta: got %h expected 000", out_delta); end
        if (delta_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", delta_count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        if (sat_count !== 2'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(8'd10, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_first_no_output: got %b expected 0", out_valid); end
        send(8'd13, 1'b0);
        checks++;
        if (out_delta !== 9'h003) begin errors++; $display("FAIL basic_plus3: got %h expected 003", out_delta); end
        send(8'd5, 1'b0);
        checks++;
        if (out_delta !== 9'h1F8) begin errors++; $display("FAIL basic_minus8: got %h expected 1f8", out_delta); end
        idle(2);
        checks++;
        if (delta_count !== 16'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", delta_count); end
        check_drained("basic");
    endtask

    task automatic test_extremes();
        out_ready = 1'b1;
        send(8'd0, 1'b1);
        send(8'd255, 1'b0);
        checks++;
        if (out_delta !== 9'h0FF) begin errors++; $display("FAIL extreme_plus255: got %h expected 0ff", out_delta); end
        send(8'd0, 1'b0);
        checks++;
        if (out_delta !== 9'h101) begin errors++; $display("FAIL extreme_minus255: got %h expected 101", out_delta); end
        idle(2);
        checks++;
        if (delta_count !== 16'd4) begin errors++; $display("FAIL extreme_count: got %0d expected 4", delta_count); end
        check_drained("extremes");
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        send(8'd20, 1'b1);
        send(8'd30, 1'b0);
        out_ready = 1'b0;
        in_sample = 8'd99;
        in_valid  = 1'b1;
        repeat (5) begin
            @(negedge clock);
            checks += 3;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
            if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_out_valid: got %b expected 1", out_valid); end
            if (out_delta !== 9'h00A) begin errors++; $display("FAIL stall_hold_delta: got %h expected 00a", out_delta); end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(8'd99, 1'b0);
        checks++;
        if (out_delta !== 9'h045) begin errors++; $display("FAIL stall_release_delta: got %h expected 045", out_delta); end
        idle(2);
        check_drained("backpressure");
    endtask

    task automatic test_flush();
        out_ready = 1'b1;
        send(8'd50, 1'b1);
        send(8'd60, 1'b0);
        send(8'd7, 1'b1);
        send(8'd9, 1'b0);
        checks++;
        if (out_delta !== 9'h002) begin errors++; $display("FAIL flush_plus2: got %h expected 002", out_delta); end
        idle(2);
        check_drained("flush");
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(i[7:0], 1'b0);
        out_ready = 1'b0;
        checks += 2;
        if (delta_count !== 16'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", delta_count); end
        if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_pending: got %b expected 1", out_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        checks += 4;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
        if (out_delta !== 9'h000) begin errors++; $display("FAIL mid_out_delta: got %h expected 000", out_delta); end
        if (delta_count !== 16'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", delta_count); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        have_prev = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        send(8'd77, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_first_after_reset: got %b expected 0", out_valid); end
        idle(2);
        check_drained("reset_mid");
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        apply_reset();
        out_ready = 1'b1;
        send(8'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            send(i[7:0] * 8'd3, 1'b0);
            @(posedge clock); #1;
            exp_sat = (i >= 3) ? 2'd3 : i[1:0];
            checks += 2;
            if (sat_count !== exp_sat) begin errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", i, sat_count, exp_sat); end
            if (delta_count !== i[15:0]) begin errors++; $display("FAIL wide_count_%0d: got %0d expected %0d", i, delta_count, i); end
        end
        check_drained("saturation");
    endtask

    initial begin
        reset_n   = 1'b1;
        in_sample = '0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        have_prev = 1'b0;
        model_prev = '0;
        test_reset();
        test_basic();
        test_extremes();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
